bcd_serial_subtractor: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_sub.sv | 22 ++
 rtl/bcd_serial_subtractor.sv | 152 +++++++++++++++
 tb/tb_bcd_serial_subtractor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants, FSM state encoding and digit validity helper for the
// digit-serial BCD arithmetic blocks.
package bcd_pkg;

    localparam int BCD_W   = 4;
    localparam int BCD_MAX = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        NEG  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic is_bcd_digit(input logic [BCD_W-1:0] d);
        return (d <= BCD_W'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One-digit BCD subtractor: d = x - y - bin, corrected into 0..9 with a
// borrow out whenever the raw difference goes negative.
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] x,
    input  logic [BCD_W-1:0] y,
    input  logic             bin,
    output logic [BCD_W-1:0] d,
    output logic             bout
);

    // One extra bit holds the sign; the most negative value is 0-9-1 = -10.
    logic [BCD_W:0] t;

    always_comb begin
        t    = {1'b0, x} - {1'b0, y} - {{BCD_W{1'b0}}, bin};
        bout = t[BCD_W];
        d    = bout ? (t[BCD_W-1:0] + BCD_W'(10)) : t[BCD_W-1:0];
    end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD |a - b| in sign-magnitude form: a borrow-chained
// subtract pass, then a ten's-complement pass when the result is negative.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BCD_W*NDIG-1:0] a,
    input  logic [BCD_W*NDIG-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [BCD_W*NDIG-1:0] diff,
    output logic                neg,
    output logic                err
);

    localparam int W     = BCD_W * NDIG;
    localparam int CNT_W = $clog2(NDIG + 1);

    // Handshake: start is accepted on any edge where the FSM sits in IDLE or
    // DONE; it is ignored otherwise. done is a one-cycle pulse that coincides
    // with diff/neg/err being updated, and busy drops on that same edge.

    state_t             state, state_nxt;
    logic [W-1:0]       a_sh, b_sh, res, res_shift;
    logic [CNT_W-1:0]   cnt;
    logic               borrow, neg_r, err_r;
    logic               ops_ok, accept, last_dig;
    logic [BCD_W-1:0]   sub_x, sub_y, sub_d;
    logic               sub_bout;

    always_comb begin
        ops_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!is_bcd_digit(a[i*BCD_W +: BCD_W]) || !is_bcd_digit(b[i*BCD_W +: BCD_W]))
                ops_ok = 1'b0;
        end
    end

    assign accept   = start && ((state == IDLE) || (state == DONE));
    assign last_dig = (cnt == CNT_W'(NDIG - 1));

    // One digit slice serves both passes; NEG subtracts the result from zero.
    always_comb begin
        sub_x = (state == NEG) ? '0 : a_sh[BCD_W-1:0];
        sub_y = (state == NEG) ? res[BCD_W-1:0] : b_sh[BCD_W-1:0];
    end

    bcd_digit_sub u_digit_sub (
        .x    (sub_x),
        .y    (sub_y),
        .bin  (borrow),
        .d    (sub_d),
        .bout (sub_bout)
    );

    // New digits enter at the MSD end so digit 0 ends up in bits [3:0].
    assign res_shift = (res >> BCD_W) | (W'(sub_d) << (W - BCD_W));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = ops_ok ? SUB : DONE;
            SUB:  if (last_dig) state_nxt = sub_bout ? NEG : DONE;
            NEG:  if (last_dig) state_nxt = DONE;
            DONE: begin
                if (accept) state_nxt = ops_ok ? SUB : DONE;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            neg_r  <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res    <= '0;
                        cnt    <= '0;
                        borrow <= 1'b0;
                        neg_r  <= 1'b0;
                        err_r  <= !ops_ok;
                    end
                end
                SUB: begin
                    res  <= res_shift;
                    a_sh <= a_sh >> BCD_W;
                    b_sh <= b_sh >> BCD_W;
                    if (last_dig) begin
                        cnt    <= '0;
                        borrow <= 1'b0;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        borrow <= sub_bout;
                    end
                end
                NEG: begin
                    res <= res_shift;
                    if (last_dig) begin
                        cnt    <= '0;
                        borrow <= 1'b0;
                        neg_r  <= 1'b1;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        borrow <= sub_bout;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs update only on leaving DONE, so partial results never show.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            diff <= '0;
            neg  <= 1'b0;
            err  <= 1'b0;
        end else begin
            busy <= (state == SUB) || (state == NEG) ||
                    (state_nxt == SUB) || (state_nxt == NEG);
            done <= (state == DONE);
            if (state == DONE) begin
                diff <= res;
                neg  <= neg_r;
                err  <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Bench for bcd_serial_subtractor (NDIG=4): directed and random operations
// checked against an integer-arithmetic reference model.
module tb_bcd_serial_subtractor;

    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, neg, err;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_neg_q[$];
    logic         exp_err_q[$];
    int           exp_lat_q[$];

    bcd_serial_subtractor #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .neg   (neg),
        .err   (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit valid_bcd(input logic [W-1:0] v);
        for (int i = 0; i < NDIG; i++)
            if (v[i*4 +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < NDIG; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: pushes expected diff/neg/err and latency for one operation.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int va, vb;
        if (!valid_bcd(ma) || !valid_bcd(mb)) begin
            exp_q.push_back('0); exp_neg_q.push_back(1'b0);
            exp_err_q.push_back(1'b1); exp_lat_q.push_back(1);
        end else begin
            va = bcd_to_int(ma);
            vb = bcd_to_int(mb);
            exp_q.push_back(int_to_bcd(va >= vb ? va - vb : vb - va));
            exp_neg_q.push_back(va < vb);
            exp_err_q.push_back(1'b0);
            exp_lat_q.push_back(va >= vb ? NDIG + 1 : 2 * NDIG + 1);
        end
    endtask

    // Drives start so that it is sampled at the next rising edge (E0),
    // then returns 1ns after E0 with start low.
    task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input string tag);
        @(negedge clk);
        a = sa; b = sb; start = 1'b1;
        model(sa, sb);
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy_rise"}, busy, valid_bcd(sa) && valid_bcd(sb));
    endtask

    // Counts edges after E0 (starting at lat0) until done is seen; returns in the done cycle.
    task automatic wait_done(input int lat0, input string tag);
        int lat = lat0;
        bit seen = 1'b0;
        logic [W-1:0] ed;
        while (!seen && lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (done === 1'b1) seen = 1'b1;
        end
        ed = exp_q.pop_front();
        check({tag, "_seen"}, seen, 1'b1);
        check({tag, "_lat"}, lat, exp_lat_q.pop_front());
        check({tag, "_diff"}, diff, ed);
        check({tag, "_neg"}, neg, exp_neg_q.pop_front());
        check({tag, "_err"}, err, exp_err_q.pop_front());
        check({tag, "_busy_fall"}, busy, 1'b0);
    endtask

    task automatic run_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input string tag);
        start_op(sa, sb, tag);
        wait_done(0, tag);
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] r;
        for (int i = 0; i < NDIG; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
        if ($urandom_range(0, 7) == 0) r[$urandom_range(0, NDIG - 1)*4 +: 4] = 4'($urandom_range(10, 15));
        return r;
    endfunction

    initial begin
        bit saw_done;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, '0);
        check("rst_neg", neg, 1'b0);
        check("rst_err", err, 1'b0);

        run_op(16'h0042, 16'h0017, "pos");
        run_op(16'h0017, 16'h0042, "negres");
        @(posedge clk);
        #1 check("done_pulse_one_cycle", done, 1'b0);
        check("diff_hold", diff, 16'h0025);
        run_op(16'h1000, 16'h0001, "borrow_chain");
        run_op(16'h0000, 16'h9999, "max_neg");
        run_op(16'h5555, 16'h5555, "zero");
        run_op(16'h00A0, 16'h0001, "invalid");
        run_op(16'h0042, 16'h0017, "err_clear");

        // Second start during SUB at E0+2 must be ignored.
        start_op(16'h0042, 16'h0017, "ign");
        @(posedge clk);
        @(negedge clk);
        a = 16'h0017; b = 16'h0042; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(2, "ign");

        // Back-to-back: start asserted in the done cycle.
        start_op(16'h0100, 16'h0099, "b2b_first");
        wait_done(0, "b2b_first");
        a = 16'h0099; b = 16'h0100; start = 1'b1;
        model(16'h0099, 16'h0100);
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_busy_no_gap", busy, 1'b1);
        wait_done(0, "b2b_second");

        // Reset at E0+3 abandons the operation.
        start_op(16'h0042, 16'h0017, "rst_mid");
        void'(exp_q.pop_front()); void'(exp_neg_q.pop_front());
        void'(exp_err_q.pop_front()); void'(exp_lat_q.pop_front());
        @(posedge clk);
        @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
        check("rst_mid_diff", diff, '0);
        check("rst_mid_neg", neg, 1'b0);
        check("rst_mid_err", err, 1'b0);
        saw_done = 1'b0;
        repeat (2 * NDIG + 4) begin
            @(posedge clk);
            #1 if (done === 1'b1) saw_done = 1'b1;
        end
        check("rst_mid_no_done", saw_done, 1'b0);
        run_op(16'h0042, 16'h0017, "after_rst");

        for (int i = 0; i < 24; i++) run_op(rand_operand(), rand_operand(), "rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
